_shift_reg_en: RTL and testbench
================================

Name: _shift_reg_en

Overview:
- Parametrised universal shift register with clock enable; next generation of the single-bit enabled D flip-flop.
- Generalised to WIDTH bits, with modes: hold, parallel load, shift left/right with serial inputs, rotate left/right, and synchronous clear.
- A saturating shift counter flags when a full word has been shifted through since the last load or clear.
- Used as a SIPO/PISO building block and as a generic enabled register bank.

Parameters:
- WIDTH, 8, data width in bits; legal range 2 to 64.
- RESET_VAL, 0, value q takes on asynchronous reset (WIDTH bits).
- CNT_W, $clog2(WIDTH+1), counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; 0 means all state holds.
- mode  input  3  operation select (see Behaviour).
- d  input  WIDTH  parallel load data.
- si_l  input  1  serial in at the MSB, used for shift right.
- si_r  input  1  serial in at the LSB, used for shift left.
- q  output  WIDTH  register contents.
- so_l  output  1  q[WIDTH-1]; combinational from q.
- so_r  output  1  q[0]; combinational from q.
- cnt  output  CNT_W  shifts since last load/clear, saturating at WIDTH.
- done  output  1  high while cnt == WIDTH; combinational from cnt.

Behaviour:
- Reset: reset_n=0 forces q=RESET_VAL and cnt=0 immediately, independent of clk. This gives done=0, so_l=RESET_VAL[WIDTH-1] and so_r=RESET_VAL[0]. Reset asserted mid-operation aborts it; no partial update.
- All state updates on the rising edge of clk, with 1-cycle latency.
- en=0: q and cnt hold regardless of mode, d and the serial inputs.
- en=1, mode decode:
  - 000 hold: q and cnt unchanged.
  - 001 load: q<=d; cnt<=0.
  - 010 shift left: q<={q[WIDTH-2:0],si_r}; the bit shifted out is the pre-edge so_l.
  - 011 shift right: q<={si_l,q[WIDTH-1:1]}; the bit shifted out is the pre-edge so_r.
  - 100 rotate left: q<={q[WIDTH-2:0],q[WIDTH-1]}.
  - 101 rotate right: q<={q[0],q[WIDTH-1:1]}.
  - 110 clear: q<=0 (not RESET_VAL); cnt<=0.
  - 111 reserved: treated as hold; no X propagation.
- Counter:
  - Each enabled shift or rotate (modes 010-101) increments cnt when cnt<WIDTH.
  - At cnt==WIDTH it holds; no wrap-around.
  - Load and clear take priority and zero cnt in the same edge.
- done rises in the cycle after the WIDTH-th enabled shift edge. It stays high until a load, clear or reset.
- Serial inputs are sampled only at the edge and only in their own shift mode; they are ignored otherwise.

Optional Feature:
- Macro: SHIFT_REG_PARITY_EN.
- Defined:
  - Adds output port par, 1 bit, a registered even-parity bit.
  - Updates on the same edge as q so that par == ^q at all times.
  - Reset value is ^RESET_VAL; it holds when en=0.
- Undefined: port par and its flop are absent. All other behaviour is identical.

Test Plan (WIDTH=8, RESET_VAL=8'h00):
- Reset: load 8'hA5, then drop reset_n between clock edges -> q=8'h00 and cnt=0 at once, done=0; release -> q remains 8'h00 until the next enabled op.
- Enable gating: en=1, mode=001, d=8'hA5 -> q=8'hA5, cnt=0 after 1 edge. Then en=0, mode=001, d=8'hFF for 3 edges -> q stays 8'hA5.
- Shift left: q=8'hA5, si_r=1, mode=010 -> so_l=1 before the edge, q=8'h4B and cnt=1 after. Then mode=011, si_l=0 -> q=8'h25, cnt=2.
- Rotate and saturation: load 8'h81, then mode=101 for 8 edges -> q=8'h81, cnt=8, done=1 after the 8th edge. A 9th rotate -> q=8'hC0, cnt stays 8, done=1. Then mode=110 -> q=8'h00, cnt=0, done=0.
- Reserved mode: q=8'h3C, mode=111, en=1 for 2 edges -> q=8'h3C, cnt unchanged. Rotate left from 8'h3C -> 8'h78.
- Parity (macro defined): load 8'h07 -> par=1; shift left with si_r=0 -> q=8'h0E, par=1; load 8'h03 -> par=0; par==^q checked on every cycle.

Source files
------------

// File: rtl/_shift_reg_en.sv
// _shift_reg_en: universal WIDTH-bit shift register with clock enable and saturating shift counter.
// Define SHIFT_REG_PARITY_EN to add a registered even-parity output par.
module _shift_reg_en #(
    parameter int             WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int            CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             si_l,
    input  logic             si_r,
    output logic [WIDTH-1:0] q,
    output logic             so_l,
    output logic             so_r,
    output logic [CNT_W-1:0] cnt,
    output logic             done
`ifdef SHIFT_REG_PARITY_EN
    ,
    output logic             par
`endif
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shift, zero_cnt, full;

    assign full = cnt_q == CNT_W'(WIDTH);

    always_comb begin
        data_d   = data_q;
        shift    = 1'b0;
        zero_cnt = 1'b0;
        if (en) begin
            case (mode)
                3'b001:  begin data_d = d; zero_cnt = 1'b1; end
                3'b010:  begin data_d = {data_q[WIDTH-2:0], si_r}; shift = 1'b1; end
                3'b011:  begin data_d = {si_l, data_q[WIDTH-1:1]}; shift = 1'b1; end
                3'b100:  begin data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]}; shift = 1'b1; end
                3'b101:  begin data_d = {data_q[0], data_q[WIDTH-1:1]}; shift = 1'b1; end
                3'b110:  begin data_d = '0; zero_cnt = 1'b1; end
                default: data_d = data_q;
            endcase
        end
        cnt_d = zero_cnt ? '0 : (shift && !full) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VAL;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q    = data_q;
    assign so_l = data_q[WIDTH-1];
    assign so_r = data_q[0];
    assign cnt  = cnt_q;
    assign done = full;

`ifdef SHIFT_REG_PARITY_EN
    logic par_q, par_d;

    // Parity follows the next data word so it lands on the same edge as q.
    always_comb par_d = ^data_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) par_q <= ^RESET_VAL;
        else          par_q <= par_d;
    end

    assign par = par_q;
`endif

endmodule

// File: tb/tb__shift_reg_en.sv
// tb__shift_reg_en: table-driven directed bench for _shift_reg_en at WIDTH=8, RESET_VAL=0.
module tb__shift_reg_en;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       si_l, si_r;
    logic [7:0] q;
    logic       so_l, so_r;
    logic [3:0] cnt;
    logic       done;
`ifdef SHIFT_REG_PARITY_EN
    logic       par;
`endif

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       si_l;
        logic       si_r;
        logic [7:0] q;
        logic [3:0] cnt;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    _shift_reg_en #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .d(d),
        .si_l(si_l), .si_r(si_r), .q(q), .so_l(so_l), .so_r(so_r),
        .cnt(cnt), .done(done)
`ifdef SHIFT_REG_PARITY_EN
        , .par(par)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic e, input logic [2:0] m, input logic [7:0] dd, input logic sl,
                       input logic sr, input logic [7:0] eq, input logic [3:0] ec, input logic ed);
        vec_t v;
        v.en = e; v.mode = m; v.d = dd; v.si_l = sl; v.si_r = sr;
        v.q = eq; v.cnt = ec; v.done = ed;
        vecs.push_back(v);
    endtask

    task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dd,
                        input logic sl, input logic sr);
        en = e; mode = m; d = dd; si_l = sl; si_r = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eq, input logic [3:0] ec, input logic ed);
        chk({tag, ".q"}, q, eq);
        chk({tag, ".cnt"}, 8'(cnt), 8'(ec));
        chk({tag, ".done"}, 8'(done), 8'(ed));
        chk({tag, ".so_l"}, 8'(so_l), 8'(eq[7]));
        chk({tag, ".so_r"}, 8'(so_r), 8'(eq[0]));
`ifdef SHIFT_REG_PARITY_EN
        chk({tag, ".par"}, 8'(par), 8'(^eq));
`endif
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; mode = 3'b000; d = 8'h00; si_l = 1'b0; si_r = 1'b0;
        // Enable gating and load
        add(1, 3'b001, 8'hA5, 0, 0, 8'hA5, 4'd0, 0);
        add(0, 3'b001, 8'hFF, 1, 1, 8'hA5, 4'd0, 0);
        add(0, 3'b010, 8'hFF, 1, 1, 8'hA5, 4'd0, 0);
        add(0, 3'b110, 8'hFF, 1, 1, 8'hA5, 4'd0, 0);
        // Shift left then right
        add(1, 3'b010, 8'h00, 0, 1, 8'h4B, 4'd1, 0);
        add(1, 3'b011, 8'h00, 0, 0, 8'h25, 4'd2, 0);
        // Rotate right to saturation
        add(1, 3'b001, 8'h81, 0, 0, 8'h81, 4'd0, 0);
        add(1, 3'b101, 8'h00, 1, 1, 8'hC0, 4'd1, 0);
        add(1, 3'b101, 8'h00, 0, 0, 8'h60, 4'd2, 0);
        add(1, 3'b101, 8'h00, 0, 0, 8'h30, 4'd3, 0);
        add(1, 3'b101, 8'h00, 0, 0, 8'h18, 4'd4, 0);
        add(1, 3'b101, 8'h00, 0, 0, 8'h0C, 4'd5, 0);
        add(1, 3'b101, 8'h00, 0, 0, 8'h06, 4'd6, 0);
        add(1, 3'b101, 8'h00, 0, 0, 8'h03, 4'd7, 0);
        add(1, 3'b101, 8'h00, 0, 0, 8'h81, 4'd8, 1);
        add(1, 3'b101, 8'h00, 0, 0, 8'hC0, 4'd8, 1);
        add(1, 3'b010, 8'h00, 0, 0, 8'h80, 4'd8, 1);
        add(1, 3'b110, 8'hFF, 1, 1, 8'h00, 4'd0, 0);
        // Reserved and hold modes, rotate left ignores serial inputs
        add(1, 3'b001, 8'h3C, 0, 0, 8'h3C, 4'd0, 0);
        add(1, 3'b111, 8'hFF, 1, 1, 8'h3C, 4'd0, 0);
        add(1, 3'b111, 8'hFF, 1, 1, 8'h3C, 4'd0, 0);
        add(1, 3'b100, 8'h00, 0, 0, 8'h78, 4'd1, 0);
        add(1, 3'b111, 8'h00, 0, 0, 8'h78, 4'd1, 0);
        add(1, 3'b000, 8'hFF, 1, 1, 8'h78, 4'd1, 0);
        add(0, 3'b100, 8'h00, 0, 0, 8'h78, 4'd1, 0);
        add(1, 3'b100, 8'h00, 1, 1, 8'hF0, 4'd2, 0);
        add(1, 3'b010, 8'h00, 1, 0, 8'hE0, 4'd3, 0);
        add(1, 3'b011, 8'h00, 1, 0, 8'hF0, 4'd4, 0);
        add(1, 3'b011, 8'h00, 0, 1, 8'h78, 4'd5, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 8'h00, 4'd0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 4) chk("pre_shift.so_l", 8'(so_l), 8'd1);
            step(vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].si_l, vecs[i].si_r);
            chk_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].cnt, vecs[i].done);
        end

`ifdef SHIFT_REG_PARITY_EN
        step(1, 3'b001, 8'h07, 0, 0);
        chk("par07", 8'(par), 8'd1);
        step(1, 3'b010, 8'h00, 0, 0);
        chk("par0E.q", q, 8'h0E);
        chk("par0E", 8'(par), 8'd1);
        step(1, 3'b001, 8'h03, 0, 0);
        chk("par03", 8'(par), 8'd0);
`endif

        // Asynchronous reset between edges, held across an enabled load edge
        step(1, 3'b001, 8'hA5, 0, 0);
        step(1, 3'b010, 8'h00, 0, 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk_all("async_rst", 8'h00, 4'd0, 0);
        en = 1'b1; mode = 3'b001; d = 8'hFF;
        @(posedge clk);
        #1;
        chk_all("rst_held", 8'h00, 4'd0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 3'b001, 8'hFF, 0, 0);
        chk_all("post_rst", 8'h00, 4'd0, 0);
        step(1, 3'b010, 8'h00, 0, 1);
        chk_all("post_rst_shift", 8'h01, 4'd1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
